// File: rtl/shift_pkg.sv
// Shared types for the shift pipeline.
// Mode encoding matches the in_mode port bits.
package shift_pkg;

  localparam int SHIFT_N = 3;

  typedef enum logic [1:0] {
    SHR_LOG = 2'b00,
    SHL_LOG = 2'b01,
    ROR     = 2'b10,
    ROL     = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter.
// Left modes reuse the right shifter between two bit reversals.
module shift_core
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic [2**N-1:0] data,
  input  logic [N-1:0]    amt,
  input  shift_mode_t     mode,
  output logic [2**N-1:0] res
);

  localparam int W = 2**N;

  logic           left;
  logic           rot;
  logic [W-1:0]   din;
  logic [W-1:0]   shr;
  logic [2*W-1:0] dbl;

  always_comb begin
    left = 1'b0;
    rot  = 1'b0;
    unique case (mode)
      SHR_LOG: begin left = 1'b0; rot = 1'b0; end
      SHL_LOG: begin left = 1'b1; rot = 1'b0; end
      ROR:     begin left = 1'b0; rot = 1'b1; end
      ROL:     begin left = 1'b1; rot = 1'b1; end
    endcase
  end

  always_comb begin
    din = '0;
    for (int i = 0; i < W; i++)
      din[i] = left ? data[W-1-i] : data[i];
  end

  // Doubling the word makes the rotate a plain right shift.
  always_comb begin
    dbl = {din, din} >> amt;
    shr = rot ? dbl[W-1:0] : (din >> amt);
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < W; i++)
      res[i] = left ? shr[W-1-i] : shr[i];
  end

endmodule

// File: rtl/shift_pipe_ctrl.sv
// Two-stage shift pipeline with valid/ready handshake
// and a saturating delivered-result counter.
module shift_pipe_ctrl
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] in_data,
  input  logic [N-1:0]    in_amt,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_data,
  output logic [15:0]     out_count
);

  localparam int W = 2**N;

  logic          s1_valid;
  logic [W-1:0]  s1_data;
  logic [N-1:0]  s1_amt;
  shift_mode_t   s1_mode;

  logic          s2_valid;
  logic [W-1:0]  s2_data;
  logic [15:0]   count_q;

  logic          s2_fire;
  logic          s2_load;
  logic          s1_advance;
  logic          accept;
  logic [W-1:0]  core_res;

  shift_core #(.N(N)) u_core (
    .data (s1_data),
    .amt  (s1_amt),
    .mode (s1_mode),
    .res  (core_res)
  );

  // Ready ripples back from out_ready so a full pipe streams without bubbles.
  assign s2_fire    = s2_valid && out_ready;
  assign s2_load    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_amt   <= '0;
      s1_mode  <= SHR_LOG;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_amt   <= in_amt;
      s1_mode  <= shift_mode_t'(in_mode);
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= core_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (s2_fire && count_q != 16'hFFFF)
      count_q <= count_q + 16'd1;
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_count = count_q;

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Directed self-checking bench for shift_pipe_ctrl.
// Expected values are hand-computed constants.
module tb_shift_pipe_ctrl;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_amt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [15:0]  out_count;

  int checks = 0;
  int errors = 0;

  shift_pipe_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic single(input string tag,
                        input logic [7:0] d,
                        input logic [2:0] a,
                        input logic [1:0] m,
                        input logic [7:0] exp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
  endtask

  logic [7:0] sd [8];
  logic [7:0] se [8];
  logic [7:0] q [$];
  logic [15:0] sat_exp [3];

  initial begin
    int sent;
    int got;
    int occ;
    int full_seen;
    int stale;
    bit acc;
    bit dlv;

    sd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    se = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};
    sat_exp = '{16'hFFFE, 16'hFFFF, 16'hFFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    single("shr3", 8'hB1, 3'd3, 2'b00, 8'h16);
    single("shl3", 8'hB1, 3'd3, 2'b01, 8'h88);
    single("ror3", 8'hB1, 3'd3, 2'b10, 8'h36);
    single("rol3", 8'hB1, 3'd3, 2'b11, 8'h8D);
    single("shr0", 8'h5A, 3'd0, 2'b00, 8'h5A);
    single("shl0", 8'h5A, 3'd0, 2'b01, 8'h5A);
    single("ror0", 8'h5A, 3'd0, 2'b10, 8'h5A);
    single("rol0", 8'h5A, 3'd0, 2'b11, 8'h5A);
    single("shr7", 8'h80, 3'd7, 2'b00, 8'h01);

    // Fresh counter for the stream.
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    sent = 0;
    got = 0;
    occ = 0;
    full_seen = 0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? sd[sent] : 8'h00;
      in_amt    = 3'd4;
      in_mode   = 2'b10;
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (occ == 2 && !out_ready) begin
        chk("stream_full_rdy", 32'(in_ready), 32'd0);
        full_seen++;
      end
      if (dlv) begin
        chk("stream_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0)
          chk("stream_data", 32'(out_data), 32'(q.pop_front()));
        got++;
      end
      if (acc) begin
        q.push_back(se[sent]);
        sent++;
      end
      occ = occ + int'(acc) - int'(dlv);
    end
    chk("stream_got", 32'(got), 32'd8);
    chk("stream_qempty", 32'(q.size()), 32'd0);
    chk("stream_full_seen", 32'(full_seen > 0), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_count", 32'(out_count), 32'd8);

    @(negedge clk);
    force dut.count_q = 16'hFFFD;
    #1 release dut.count_q;
    #1 chk("sat_preload", 32'(out_count), 32'hFFFD);
    for (int k = 0; k < 3; k++) begin
      single("sat_pass", 8'h01, 3'd1, 2'b01, 8'h02);
      @(negedge clk);
      #1 chk("sat_count", 32'(out_count), 32'(sat_exp[k]));
    end

    // Two requests in flight, then reset.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    in_amt    = 3'd1;
    in_mode   = 2'b00;
    @(negedge clk);
    in_data = 8'h55;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 chk("mid_inflight", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_count", 32'(out_count), 32'd0);
    chk("mid_rst_rdy",   32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    chk("mid_count", 32'(out_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
